// File: rtl/get_certificate_request_pkg.sv
// Shared constants for the GET_CERTIFICATE requester.
// Contents: message geometry, protocol opcodes, the per-slot certificate
// chunk lengths and counts, error codes, FSM state encodings, and a helper
// that builds the answer header the responder is expected to return.
package get_certificate_request_pkg;

    // Message geometry
    localparam int SIZE_OF_HEADER_VARS     = 8;
    localparam int SIZE_OF_HEADER_IN_BYTES = 4;
    localparam int HDR_W                   = SIZE_OF_HEADER_VARS * SIZE_OF_HEADER_IN_BYTES;
    localparam int MSG_LEN                 = 128;
    localparam int PAYLOAD_W               = MSG_LEN - 32;

    typedef logic [15:0] chunk_len_t;
    typedef logic [3:0]  chunk_idx_t;

    // Protocol opcodes
    localparam logic [7:0] PROTOCOL_VERSION       = 8'h10;
    localparam logic [7:0] CERTIFICATE_ANSWER_CMD = 8'h02;
    localparam logic [7:0] GET_CERTIFICATE_CMD    = 8'h82;

    // Certificate chunk lengths per slot
    localparam chunk_len_t SLOT0_CERT1_LENGTH = 16'h0120;
    localparam chunk_len_t SLOT0_CERT2_LENGTH = 16'h0200;
    localparam chunk_len_t SLOT0_CERT3_LENGTH = 16'h0180;
    localparam chunk_len_t SLOT0_CERT4_LENGTH = 16'h0040;
    localparam chunk_len_t SLOT0_CERT5_LENGTH = 16'h0300;
    localparam chunk_len_t SLOT0_CERT6_LENGTH = 16'h0064;
    localparam chunk_len_t SLOT1_CERT1_LENGTH = 16'h0400;
    localparam chunk_len_t SLOT1_CERT2_LENGTH = 16'h0250;
    localparam chunk_len_t SLOT1_CERT3_LENGTH = 16'h0111;
    localparam chunk_len_t SLOT1_CERT4_LENGTH = 16'h0090;
    localparam chunk_len_t SLOT2_CERT1_LENGTH = 16'h0070;
    localparam chunk_len_t SLOT2_CERT2_LENGTH = 16'h0333;
    localparam chunk_len_t SLOT2_CERT3_LENGTH = 16'h0222;
    localparam chunk_len_t SLOT2_CERT4_LENGTH = 16'h0155;
    localparam chunk_len_t SLOT2_CERT5_LENGTH = 16'h0044;

    // Number of chunks in each slot's chain
    localparam chunk_idx_t SLOT0_NUM_CERTS = 4'd6;
    localparam chunk_idx_t SLOT1_NUM_CERTS = 4'd4;
    localparam chunk_idx_t SLOT2_NUM_CERTS = 4'd5;

    // Error codes
    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_BAD_SLOT     = 3'd1;
    localparam logic [2:0] ERR_RESP_INVALID = 3'd2;
    localparam logic [2:0] ERR_HDR_MISMATCH = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT      = 3'd4;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_DELIVER = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_ERR     = 3'd7;

    // Header a well-formed CERTIFICATE answer must carry for a given slot
    function automatic logic [HDR_W-1:0] answer_header(input logic [SIZE_OF_HEADER_VARS-1:0] slot);
        return {PROTOCOL_VERSION, CERTIFICATE_ANSWER_CMD, slot, 8'h00};
    endfunction

endpackage

// File: rtl/get_certificate_request_cert_chunk_table.sv
// cert_chunk_table: combinational lookup of the certificate chain layout.
// Ports:
//   slot       in  slot number
//   index      in  chunk index within the slot's chain
//   length     out length of that chunk (0 when out of range)
//   num_chunks out number of chunks in the slot's chain (0 for bad slots)
//   slot_valid out 1 for slots 0..2
module cert_chunk_table
    import get_certificate_request_pkg::*;
(
    input  logic [SIZE_OF_HEADER_VARS-1:0] slot,
    input  chunk_idx_t                     index,
    output chunk_len_t                     length,
    output chunk_idx_t                     num_chunks,
    output logic                           slot_valid
);

    always_comb begin
        length     = '0;
        num_chunks = '0;
        slot_valid = 1'b0;
        case (slot)
            SIZE_OF_HEADER_VARS'(0): begin
                slot_valid = 1'b1;
                num_chunks = SLOT0_NUM_CERTS;
                case (index)
                    4'd0:    length = SLOT0_CERT1_LENGTH;
                    4'd1:    length = SLOT0_CERT2_LENGTH;
                    4'd2:    length = SLOT0_CERT3_LENGTH;
                    4'd3:    length = SLOT0_CERT4_LENGTH;
                    4'd4:    length = SLOT0_CERT5_LENGTH;
                    4'd5:    length = SLOT0_CERT6_LENGTH;
                    default: length = '0;
                endcase
            end
            SIZE_OF_HEADER_VARS'(1): begin
                slot_valid = 1'b1;
                num_chunks = SLOT1_NUM_CERTS;
                case (index)
                    4'd0:    length = SLOT1_CERT1_LENGTH;
                    4'd1:    length = SLOT1_CERT2_LENGTH;
                    4'd2:    length = SLOT1_CERT3_LENGTH;
                    4'd3:    length = SLOT1_CERT4_LENGTH;
                    default: length = '0;
                endcase
            end
            SIZE_OF_HEADER_VARS'(2): begin
                slot_valid = 1'b1;
                num_chunks = SLOT2_NUM_CERTS;
                case (index)
                    4'd0:    length = SLOT2_CERT1_LENGTH;
                    4'd1:    length = SLOT2_CERT2_LENGTH;
                    4'd2:    length = SLOT2_CERT3_LENGTH;
                    4'd3:    length = SLOT2_CERT4_LENGTH;
                    4'd4:    length = SLOT2_CERT5_LENGTH;
                    default: length = '0;
                endcase
            end
            default: begin
                slot_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/get_certificate_request.sv
// get_certificate_request: requester side of the certificate exchange.
// Fetches a slot's certificate chain one chunk at a time, issuing a
// GET_CERTIFICATE request per chunk, validating each answer header and
// handing the payload downstream over a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort, slot    control from the authentication controller
//   req_enable, req_msg   request towards the responder
//   resp_ack, resp_error, resp_header, resp_payload   responder answer
//   chunk_valid/ready, chunk_data/len/index/last      downstream chunk stream
//   busy, done, error, error_code                     status
module get_certificate_request
    import get_certificate_request_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [SIZE_OF_HEADER_VARS-1:0] slot,
    output logic                           req_enable,
    output logic [MSG_LEN-1:0]             req_msg,
    input  logic                           resp_ack,
    input  logic                           resp_error,
    input  logic [HDR_W-1:0]               resp_header,
    input  logic [PAYLOAD_W-1:0]           resp_payload,
    output logic                           chunk_valid,
    input  logic                           chunk_ready,
    output logic [PAYLOAD_W-1:0]           chunk_data,
    output logic [15:0]                    chunk_len,
    output logic [3:0]                     chunk_index,
    output logic                           chunk_last,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [2:0]                     error_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]                     state;
    logic [SIZE_OF_HEADER_VARS-1:0] slot_q;
    chunk_idx_t                     index;
    chunk_idx_t                     num_chunks;
    chunk_len_t                     length;
    logic [CNT_W-1:0]               tmo_cnt;
    logic [HDR_W-1:0]               hdr_q;
    logic [PAYLOAD_W-1:0]           payload_q;

    logic [SIZE_OF_HEADER_VARS-1:0] tbl_slot;
    chunk_len_t                     tbl_len;
    chunk_idx_t                     tbl_num;
    logic                           tbl_valid;

    // In IDLE the live slot input is checked so a bad slot is rejected in
    // the start cycle; afterwards the latched slot drives the lookup.
    assign tbl_slot = (state == ST_IDLE) ? slot : slot_q;

    cert_chunk_table u_table (
        .slot       (tbl_slot),
        .index      (index),
        .length     (tbl_len),
        .num_chunks (tbl_num),
        .slot_valid (tbl_valid)
    );

    // Decoded from the state register so they follow an asynchronous reset
    // immediately (req_enable in particular must drop without a clock).
    assign req_enable  = (state == ST_REQ);
    assign chunk_valid = (state == ST_DELIVER);
    assign chunk_last  = (state == ST_DELIVER) && (index == num_chunks - 4'd1);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign chunk_data  = payload_q;
    assign chunk_len   = length;
    assign chunk_index = index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            slot_q     <= '0;
            index      <= '0;
            num_chunks <= '0;
            length     <= '0;
            tmo_cnt    <= '0;
            hdr_q      <= '0;
            payload_q  <= '0;
            req_msg    <= '0;
            error      <= 1'b0;
            error_code <= ERR_NONE;
        end else if (abort) begin
            // Abort overrides every transition, including an accepted start
            // or an ack in the same cycle; status flags are left untouched.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        slot_q <= slot;
                        index  <= '0;
                        if (!tbl_valid) begin
                            state      <= ST_ERR;
                            error      <= 1'b1;
                            error_code <= ERR_BAD_SLOT;
                        end else begin
                            state      <= ST_LOAD;
                            error      <= 1'b0;
                            error_code <= ERR_NONE;
                        end
                    end
                end
                ST_LOAD: begin
                    length     <= tbl_len;
                    num_chunks <= tbl_num;
                    req_msg    <= {PROTOCOL_VERSION, GET_CERTIFICATE_CMD, slot_q, 8'h00,
                                   12'h000, index, tbl_len, {(MSG_LEN-64){1'b0}}};
                    tmo_cnt    <= '0;
                    state      <= ST_REQ;
                end
                ST_REQ: begin
                    // resp_error outranks a simultaneous ack. The payload is
                    // only guaranteed stable while we hold the enable, so it
                    // is captured in the ack cycle itself.
                    if (resp_error) begin
                        state      <= ST_ERR;
                        error      <= 1'b1;
                        error_code <= ERR_RESP_INVALID;
                    end else if (resp_ack) begin
                        hdr_q     <= resp_header;
                        payload_q <= resp_payload;
                        state     <= ST_CHECK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= ST_ERR;
                        error      <= 1'b1;
                        error_code <= ERR_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (hdr_q != answer_header(slot_q)) begin
                        state      <= ST_ERR;
                        error      <= 1'b1;
                        error_code <= ERR_HDR_MISMATCH;
                    end else begin
                        state <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (chunk_ready) begin
                        if (index == num_chunks - 4'd1) begin
                            state <= ST_DONE;
                        end else begin
                            index <= index + 4'd1;
                            state <= ST_GAP;
                        end
                    end
                end
                // One idle cycle lets the responder release its ack
                ST_GAP:  state <= ST_LOAD;
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
